// File: rtl/sram_arb_multi_pkg.sv
// Shared constants and FSM encoding for the multi-master SRAM arbiter.
package sram_arb_pkg;

    localparam int ARB_FIXED = 0;
    localparam int ARB_RR    = 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_e;

endpackage

// File: rtl/sram_arb_multi_if.sv
// Avalon-style multi-master request bus; master i occupies slice i of each vector.
interface sram_arb_multi_if #(
    parameter int NUM_MASTERS = 2,
    parameter int ADDR_WIDTH  = 20,
    parameter int DATA_WIDTH  = 16
);
    localparam int BE_WIDTH = DATA_WIDTH / 8;

    logic [NUM_MASTERS*ADDR_WIDTH-1:0] m_address;
    logic [NUM_MASTERS*BE_WIDTH-1:0]   m_byteenable;
    logic [NUM_MASTERS-1:0]            m_read;
    logic [NUM_MASTERS-1:0]            m_write;
    logic [NUM_MASTERS*DATA_WIDTH-1:0] m_writedata;
    logic [NUM_MASTERS-1:0]            m_waitrequest;
    logic [DATA_WIDTH-1:0]             m_readdata;
    logic [NUM_MASTERS-1:0]            m_readdataready;

    modport master (
        output m_address, m_byteenable, m_read, m_write, m_writedata,
        input  m_waitrequest, m_readdata, m_readdataready
    );

    modport slave (
        input  m_address, m_byteenable, m_read, m_write, m_writedata,
        output m_waitrequest, m_readdata, m_readdataready
    );

endinterface

// File: rtl/sram_arb_multi_pick.sv
// Winner selection: fixed priority (lowest index) or round-robin starting after ptr.
module arb_pick #(
    parameter int NUM_MASTERS = 2,
    parameter int SEL_WIDTH   = 1
) (
    input  logic [NUM_MASTERS-1:0] req,
    input  logic [SEL_WIDTH-1:0]   ptr,
    input  logic                   rr_mode,
    output logic [NUM_MASTERS-1:0] grant,
    output logic [SEL_WIDTH-1:0]   idx,
    output logic                   valid
);

    // Scan candidates in priority order; first requester found wins.
    always_comb begin
        int unsigned c;
        grant = '0;
        idx   = '0;
        valid = 1'b0;
        c     = 0;
        for (int unsigned k = 0; k < NUM_MASTERS; k++) begin
            c = rr_mode ? (32'(ptr) + k + 32'd1) % NUM_MASTERS : k;
            if (!valid && req[c]) begin
                valid    = 1'b1;
                grant[c] = 1'b1;
                idx      = SEL_WIDTH'(c);
            end
        end
    end

endmodule

// File: rtl/sram_arb_multi.sv
// Multi-master arbiter for an asynchronous SRAM with split data bus.
module sram_arb_multi
    import sram_arb_pkg::*;
#(
    parameter int NUM_MASTERS   = 2,
    parameter int ADDR_WIDTH    = 20,
    parameter int DATA_WIDTH    = 16,
    parameter int ACCESS_CYCLES = 2,
    parameter int ARB_MODE      = 1,
    localparam int BE_WIDTH     = DATA_WIDTH / 8,
    localparam int SEL_WIDTH    = $clog2(NUM_MASTERS)
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  lock_en,
    input  logic [SEL_WIDTH-1:0]  lock_sel,
    sram_arb_multi_if.slave       bus,
    output logic [ADDR_WIDTH-1:0] sram_address,
    output logic [BE_WIDTH-1:0]   sram_be_n,
    output logic                  sram_ce_n,
    output logic                  sram_oe_n,
    output logic                  sram_we_n,
    output logic [DATA_WIDTH-1:0] sram_dq_out,
    output logic                  sram_dq_oe,
    input  logic [DATA_WIDTH-1:0] sram_dq_in,
    output logic                  busy,
    output logic [SEL_WIDTH-1:0]  cur_sel
);

    state_e                 state, state_nxt;
    logic [3:0]             cnt;
    logic [SEL_WIDTH-1:0]   rr_ptr;
    logic [ADDR_WIDTH-1:0]  lat_addr;
    logic [BE_WIDTH-1:0]    lat_be;
    logic [DATA_WIDTH-1:0]  lat_wdata;
    logic                   lat_write;
    logic [NUM_MASTERS-1:0] req, grant;
    logic [SEL_WIDTH-1:0]   win_idx;
    logic                   win_valid, accept, last_cycle;

    // Eligible requesters: any command, filtered by the lock when enabled.
    always_comb begin
        req = '0;
        for (int unsigned i = 0; i < NUM_MASTERS; i++) begin
            req[i] = (bus.m_read[i] | bus.m_write[i]) &
                     (~lock_en | (lock_sel == SEL_WIDTH'(i)));
        end
    end

    arb_pick #(
        .NUM_MASTERS (NUM_MASTERS),
        .SEL_WIDTH   (SEL_WIDTH)
    ) u_pick (
        .req     (req),
        .ptr     (rr_ptr),
        .rr_mode (ARB_MODE == ARB_RR),
        .grant   (grant),
        .idx     (win_idx),
        .valid   (win_valid)
    );

    // State register.
    always_ff @(posedge clock) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // Next state, handshake and SRAM strobes.
    always_comb begin
        state_nxt         = state;
        accept            = 1'b0;
        last_cycle        = 1'b0;
        bus.m_waitrequest = '1;
        sram_ce_n         = 1'b1;
        sram_oe_n         = 1'b1;
        sram_we_n         = 1'b1;
        sram_dq_oe        = 1'b0;
        sram_be_n         = '1;
        sram_address      = lat_addr;
        sram_dq_out       = lat_wdata;
        busy              = (state != IDLE);
        case (state)
            IDLE: begin
                if (win_valid && !reset) begin
                    accept            = 1'b1;
                    bus.m_waitrequest = ~grant;
                    state_nxt         = ACCESS;
                end
            end
            ACCESS: begin
                sram_ce_n  = 1'b0;
                sram_be_n  = ~lat_be;
                sram_oe_n  = lat_write;
                sram_we_n  = ~lat_write;
                sram_dq_oe = lat_write;
                last_cycle = (cnt == 4'(ACCESS_CYCLES - 1));
                if (last_cycle) state_nxt = DONE;
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Command latch, cycle counter, arbitration pointer and read return.
    always_ff @(posedge clock) begin
        if (reset) begin
            cnt                 <= '0;
            rr_ptr              <= SEL_WIDTH'(NUM_MASTERS - 1);
            cur_sel             <= '0;
            lat_addr            <= '0;
            lat_be              <= '0;
            lat_wdata           <= '0;
            lat_write           <= 1'b0;
            bus.m_readdata      <= '0;
            bus.m_readdataready <= '0;
        end else begin
            bus.m_readdataready <= '0;
            if (accept) begin
                lat_addr  <= bus.m_address[win_idx*ADDR_WIDTH +: ADDR_WIDTH];
                lat_be    <= bus.m_byteenable[win_idx*BE_WIDTH +: BE_WIDTH];
                lat_wdata <= bus.m_writedata[win_idx*DATA_WIDTH +: DATA_WIDTH];
                lat_write <= bus.m_write[win_idx];
                rr_ptr    <= win_idx;
                cur_sel   <= win_idx;
                cnt       <= '0;
            end
            if (state == ACCESS) begin
                if (last_cycle) begin
                    cnt <= '0;
                    if (!lat_write) begin
                        bus.m_readdata      <= sram_dq_in;
                        bus.m_readdataready <= NUM_MASTERS'(1) << cur_sel;
                    end
                end else begin
                    cnt <= cnt + 4'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_sram_arb_multi.sv
// Scoreboard bench: three arbiter instances (2-master RR, 4-master RR, 4-master fixed).
module tb_sram_arb_multi;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    bit mon_on = 1'b0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    typedef struct { bit wr; logic [19:0] addr; logic [1:0] be_n; logic [15:0] data; } acc_t;
    typedef struct { int m; logic [15:0] data; } rd_t;

    acc_t exp_acc_a[$];
    rd_t  exp_rd_a[$];
    int   exp_grant_a[$], exp_grant_b[$], exp_grant_c[$];
    int   acc_cyc_a[2];
    int   grants_b = 0, grants_c = 0;

    // ---------------- instance A: 2 masters, round-robin ----------------
    sram_arb_multi_if #(.NUM_MASTERS(2), .ADDR_WIDTH(20), .DATA_WIDTH(16)) bus_a ();
    logic        lock_en_a;
    logic [0:0]  lock_sel_a, a_cur_sel;
    logic [19:0] a_addr;
    logic [1:0]  a_be_n;
    logic        a_ce_n, a_oe_n, a_we_n, a_dq_oe, a_busy;
    logic [15:0] a_dq_out, a_dq_in;

    sram_arb_multi #(.NUM_MASTERS(2), .ADDR_WIDTH(20), .DATA_WIDTH(16),
                     .ACCESS_CYCLES(2), .ARB_MODE(1)) dut_a (
        .clock(clk), .reset(rst), .lock_en(lock_en_a), .lock_sel(lock_sel_a), .bus(bus_a),
        .sram_address(a_addr), .sram_be_n(a_be_n), .sram_ce_n(a_ce_n), .sram_oe_n(a_oe_n),
        .sram_we_n(a_we_n), .sram_dq_out(a_dq_out), .sram_dq_oe(a_dq_oe), .sram_dq_in(a_dq_in),
        .busy(a_busy), .cur_sel(a_cur_sel)
    );

    logic [15:0] mem [256] = '{default: '0};
    always @(posedge clk) begin
        if (!a_ce_n && !a_we_n) begin
            if (!a_be_n[0]) mem[a_addr[7:0]][7:0]  <= a_dq_out[7:0];
            if (!a_be_n[1]) mem[a_addr[7:0]][15:8] <= a_dq_out[15:8];
        end
    end
    assign a_dq_in = (!a_ce_n && !a_oe_n) ? mem[a_addr[7:0]] : 16'h0000;

    // ---------------- instance B: 4 masters, round-robin ----------------
    sram_arb_multi_if #(.NUM_MASTERS(4), .ADDR_WIDTH(20), .DATA_WIDTH(16)) bus_b ();
    logic [1:0]  lock_sel_b, b_cur_sel;
    logic [19:0] b_addr;
    logic [1:0]  b_be_n;
    logic        b_ce_n, b_oe_n, b_we_n, b_dq_oe, b_busy;
    logic [15:0] b_dq_out;

    sram_arb_multi #(.NUM_MASTERS(4), .ADDR_WIDTH(20), .DATA_WIDTH(16),
                     .ACCESS_CYCLES(2), .ARB_MODE(1)) dut_b (
        .clock(clk), .reset(rst), .lock_en(1'b0), .lock_sel(lock_sel_b), .bus(bus_b),
        .sram_address(b_addr), .sram_be_n(b_be_n), .sram_ce_n(b_ce_n), .sram_oe_n(b_oe_n),
        .sram_we_n(b_we_n), .sram_dq_out(b_dq_out), .sram_dq_oe(b_dq_oe), .sram_dq_in(16'h0000),
        .busy(b_busy), .cur_sel(b_cur_sel)
    );

    // ---------------- instance C: 4 masters, fixed priority ----------------
    sram_arb_multi_if #(.NUM_MASTERS(4), .ADDR_WIDTH(20), .DATA_WIDTH(16)) bus_c ();
    logic [1:0]  lock_sel_c, c_cur_sel;
    logic [19:0] c_addr;
    logic [1:0]  c_be_n;
    logic        c_ce_n, c_oe_n, c_we_n, c_dq_oe, c_busy;
    logic [15:0] c_dq_out;

    sram_arb_multi #(.NUM_MASTERS(4), .ADDR_WIDTH(20), .DATA_WIDTH(16),
                     .ACCESS_CYCLES(2), .ARB_MODE(0)) dut_c (
        .clock(clk), .reset(rst), .lock_en(1'b0), .lock_sel(lock_sel_c), .bus(bus_c),
        .sram_address(c_addr), .sram_be_n(c_be_n), .sram_ce_n(c_ce_n), .sram_oe_n(c_oe_n),
        .sram_we_n(c_we_n), .sram_dq_out(c_dq_out), .sram_dq_oe(c_dq_oe), .sram_dq_in(16'h0000),
        .busy(c_busy), .cur_sel(c_cur_sel)
    );

    // ---------------- monitors ----------------
    acc_t cur;
    bit   cur_ok;
    int   alen = 0;
    rd_t  erd;

    // Grant order and no-accept-while-busy for A.
    always @(negedge clk) if (mon_on) begin
        if (a_busy) chk("a_wait_while_busy", bus_a.m_waitrequest, 2'b11);
        for (int i = 0; i < 2; i++) begin
            if ((bus_a.m_read[i] | bus_a.m_write[i]) && !bus_a.m_waitrequest[i]) begin
                acc_cyc_a[i] = cyc;
                if (exp_grant_a.size() == 0) chk("a_grant_unexpected", i, 99);
                else chk("a_grant", i, exp_grant_a.pop_front());
            end
        end
    end

    // SRAM-side access checker for A.
    always @(negedge clk) if (mon_on) begin
        if (!a_ce_n) begin
            if (alen == 0) begin
                cur_ok = (exp_acc_a.size() != 0);
                chk("a_acc_expected", cur_ok, 1);
                if (cur_ok) cur = exp_acc_a.pop_front();
            end
            alen++;
            if (cur_ok) begin
                chk("a_acc_addr", a_addr, cur.addr);
                chk("a_acc_be_n", a_be_n, cur.be_n);
                chk("a_acc_strobes", {a_oe_n, a_we_n, a_dq_oe}, cur.wr ? 3'b101 : 3'b010);
                if (cur.wr) chk("a_acc_wdata", a_dq_out, cur.data);
            end
        end else begin
            chk("a_idle_strobes", {a_oe_n, a_we_n, a_dq_oe, a_be_n}, 5'b11011);
            if (alen != 0) begin
                chk("a_acc_len", alen, 2);
                alen = 0;
            end
        end
    end

    // Read return checker for A.
    always @(negedge clk) if (mon_on && bus_a.m_readdataready != 0) begin
        if (exp_rd_a.size() == 0) chk("a_rd_unexpected", bus_a.m_readdataready, 0);
        else begin
            erd = exp_rd_a.pop_front();
            chk("a_rd_owner", bus_a.m_readdataready, 2'b01 << erd.m);
            chk("a_rd_data", bus_a.m_readdata, erd.data);
            chk("a_rd_latency", cyc - acc_cyc_a[erd.m], 3);
        end
    end

    // Grant order for B and C; C's master 2 must never be accepted.
    always @(negedge clk) if (mon_on) begin
        for (int i = 0; i < 4; i++) begin
            if ((bus_b.m_read[i] | bus_b.m_write[i]) && !bus_b.m_waitrequest[i]) begin
                grants_b++;
                if (exp_grant_b.size() == 0) chk("b_grant_unexpected", i, 99);
                else chk("b_grant", i, exp_grant_b.pop_front());
            end
            if ((bus_c.m_read[i] | bus_c.m_write[i]) && !bus_c.m_waitrequest[i]) begin
                grants_c++;
                if (exp_grant_c.size() == 0) chk("c_grant_unexpected", i, 99);
                else chk("c_grant", i, exp_grant_c.pop_front());
            end
        end
        if (bus_c.m_write[2]) chk("c_m2_waitrequest", bus_c.m_waitrequest[2], 1);
    end

    // ---------------- stimulus helpers ----------------
    task automatic req_a(input int m, input bit wr, input logic [19:0] addr,
                         input logic [1:0] be, input logic [15:0] data);
        bus_a.m_read[m]                = !wr;
        bus_a.m_write[m]               = wr;
        bus_a.m_address[m*20 +: 20]    = addr;
        bus_a.m_byteenable[m*2 +: 2]   = be;
        bus_a.m_writedata[m*16 +: 16]  = data;
    endtask

    // Hold requests until each is accepted; optionally drop the lock after an accept.
    task automatic serve_a(input bit drop_lock);
        int         n = 0;
        logic [1:0] done;
        while ((bus_a.m_read | bus_a.m_write) != 2'b00) begin
            @(negedge clk);
            done = (bus_a.m_read | bus_a.m_write) & ~bus_a.m_waitrequest;
            @(posedge clk); #1;
            bus_a.m_read  = bus_a.m_read & ~done;
            bus_a.m_write = bus_a.m_write & ~done;
            if (drop_lock && done != 2'b00) lock_en_a = 1'b0;
            n++;
            if (n > 40) begin
                chk("a_serve_timeout", n, 0);
                bus_a.m_read  = '0;
                bus_a.m_write = '0;
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        rst = 1'b1;
        lock_en_a = 1'b0; lock_sel_a = '0; lock_sel_b = '0; lock_sel_c = '0;
        bus_a.m_read = '0; bus_a.m_write = '0; bus_a.m_address = '0;
        bus_a.m_byteenable = '0; bus_a.m_writedata = '0;
        bus_b.m_read = '0; bus_b.m_write = '0; bus_b.m_address = '0;
        bus_b.m_byteenable = '1; bus_b.m_writedata = '0;
        bus_c.m_read = '0; bus_c.m_write = '0; bus_c.m_address = '0;
        bus_c.m_byteenable = '1; bus_c.m_writedata = '0;
        repeat (3) @(posedge clk); #1;

        // reset state
        chk("rst_waitrequest", bus_a.m_waitrequest, 2'b11);
        chk("rst_readdataready", bus_a.m_readdataready, 2'b00);
        chk("rst_readdata", bus_a.m_readdata, 16'h0000);
        chk("rst_strobes", {a_ce_n, a_oe_n, a_we_n, a_dq_oe, a_be_n}, 6'b111011);
        chk("rst_busy", a_busy, 0);
        chk("rst_cur_sel", a_cur_sel, 0);
        rst = 1'b0;
        mon_on = 1'b1;

        // write 0xBEEF to 0x10 then read it back
        exp_grant_a.push_back(0);
        exp_acc_a.push_back('{1'b1, 20'h00010, 2'b00, 16'hBEEF});
        req_a(0, 1'b1, 20'h00010, 2'b11, 16'hBEEF);
        serve_a(1'b0);
        chk("a_busy_access", a_busy, 1);
        exp_grant_a.push_back(0);
        exp_acc_a.push_back('{1'b0, 20'h00010, 2'b00, 16'h0000});
        exp_rd_a.push_back('{0, 16'hBEEF});
        req_a(0, 1'b0, 20'h00010, 2'b11, 16'h0000);
        serve_a(1'b0);
        repeat (8) @(posedge clk); #1;
        chk("a_readdata_hold", bus_a.m_readdata, 16'hBEEF);
        chk("a_busy_idle", a_busy, 0);

        // low-byte write, read back shows only the low byte updated
        exp_grant_a.push_back(0);
        exp_acc_a.push_back('{1'b1, 20'h00020, 2'b10, 16'h12AB});
        req_a(0, 1'b1, 20'h00020, 2'b01, 16'h12AB);
        serve_a(1'b0);
        exp_grant_a.push_back(0);
        exp_acc_a.push_back('{1'b0, 20'h00020, 2'b00, 16'h0000});
        exp_rd_a.push_back('{0, 16'h00AB});
        req_a(0, 1'b0, 20'h00020, 2'b11, 16'h0000);
        serve_a(1'b0);
        repeat (6) @(posedge clk); #1;

        // lock to master 1, release during its access, master 0 follows
        lock_en_a = 1'b1; lock_sel_a = 1'b1;
        exp_grant_a.push_back(1);
        exp_grant_a.push_back(0);
        exp_acc_a.push_back('{1'b1, 20'h00030, 2'b00, 16'h5A5A});
        exp_acc_a.push_back('{1'b0, 20'h00010, 2'b00, 16'h0000});
        exp_rd_a.push_back('{0, 16'hBEEF});
        req_a(0, 1'b0, 20'h00010, 2'b11, 16'h0000);
        req_a(1, 1'b1, 20'h00030, 2'b11, 16'h5A5A);
        serve_a(1'b1);
        chk("a_cur_sel_after_lock", a_cur_sel, 0);
        repeat (6) @(posedge clk); #1;

        // reset in the second ACCESS cycle of a read aborts it
        exp_grant_a.push_back(0);
        exp_acc_a.push_back('{1'b0, 20'h00010, 2'b00, 16'h0000});
        req_a(0, 1'b0, 20'h00010, 2'b11, 16'h0000);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (bus_a.m_waitrequest[0] && n < 20);
        if (n >= 20) chk("a_abort_accept_timeout", n, 0);
        @(posedge clk); #1;
        bus_a.m_read[0] = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        chk("abort_strobes", {a_ce_n, a_oe_n, a_we_n, a_dq_oe, a_be_n}, 6'b111011);
        chk("abort_busy", a_busy, 0);
        chk("abort_readdataready", bus_a.m_readdataready, 2'b00);
        chk("abort_readdata", bus_a.m_readdata, 16'h0000);
        chk("abort_waitrequest", bus_a.m_waitrequest, 2'b11);
        rst = 1'b0;
        repeat (6) @(posedge clk); #1;

        // 4-master round-robin: 0,1,2,3,0
        foreach (exp_grant_b[k]) exp_grant_b.delete(k);
        exp_grant_b.push_back(0); exp_grant_b.push_back(1); exp_grant_b.push_back(2);
        exp_grant_b.push_back(3); exp_grant_b.push_back(0);
        bus_b.m_read = 4'b1111;
        for (int k = 0; k < 60 && grants_b < 5; k++) @(posedge clk);
        #1 bus_b.m_read = '0;
        chk("b_grant_count", grants_b, 5);

        // fixed priority: master 1 always beats master 2
        exp_grant_c.push_back(1); exp_grant_c.push_back(1); exp_grant_c.push_back(1);
        bus_c.m_write = 4'b0110;
        for (int k = 0; k < 60 && grants_c < 3; k++) @(posedge clk);
        #1 bus_c.m_write = '0;
        chk("c_grant_count", grants_c, 3);

        repeat (8) @(posedge clk); #1;
        chk("a_grant_queue_empty", exp_grant_a.size(), 0);
        chk("a_acc_queue_empty", exp_acc_a.size(), 0);
        chk("a_rd_queue_empty", exp_rd_a.size(), 0);
        chk("b_grant_queue_empty", exp_grant_b.size(), 0);
        chk("c_grant_queue_empty", exp_grant_c.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
